dma_2d_read_master_v2: RTL and testbench

DMA_2D_READ_MASTER_V2 -- requirements
Module: dma_2d_read_master_v2

---
 rtl/dma_2d_read_master_v2_if.sv | 28 ++
 rtl/dma_2d_read_master_v2.sv | 133 +++++++++++++
 tb/tb_dma_2d_read_master_v2.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_2d_read_master_v2_if.sv
// dma_2d_read_master_v2_if: AXI4 read-address and read-data channels of the 2D read DMA.
interface dma_2d_read_master_v2_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [0:0]                    M_AXI_ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]                    M_AXI_ARLEN;
    logic [2:0]                    M_AXI_ARSIZE;
    logic [1:0]                    M_AXI_ARBURST;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RLAST;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );
endinterface

// File: rtl/dma_2d_read_master_v2.sv
// dma_2d_read_master_v2: 2D strided AXI4 read DMA feeding a FIFO, bursts issued only when FIFO credit allows.
// Define DMA2D_ERR_ABORT_EN to flag RRESP errors on sticky o_err and stop after the failing burst.
module dma_2d_read_master_v2 #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 256,
    parameter int C_FIFO_CNT_WIDTH   = 10
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
    input  logic [31:0]                   i_img_width,
    input  logic [31:0]                   i_img_height,
    input  logic [31:0]                   i_img_stride,
    input  logic [C_FIFO_CNT_WIDTH-1:0]   i_fifo_free,
    output logic                          o_fifo_push,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
    output logic                          o_busy,
    output logic                          o_read_done,
    output logic                          o_err,
    dma_2d_read_master_v2_if.master       m_axi
);
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_R, S_NEXT, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_base, r_araddr, w_addr;
    logic [31:0]     r_off, r_row_beats, r_rows, r_stride;
    logic [31:0]     w_left, w_min, w_4k, w_len, w_next_off;
    logic [12:0]     w_to4k;
    logic [8:0]      r_len;
    logic [7:0]      r_arlen;
    logic            r_done, w_row_end, w_empty, w_abort, w_beat, w_unused;

    // r_off is the byte offset inside the current row; beats are counted as r_off >> LB
    assign w_addr     = r_base + AW'(r_off);
    assign w_left     = r_row_beats - (r_off >> LB);
    assign w_to4k     = 13'h1000 - {1'b0, w_addr[11:0]};
    assign w_4k       = 32'(w_to4k >> LB);
    assign w_min      = (32'(C_M_AXI_BURST_LEN) < w_left) ? 32'(C_M_AXI_BURST_LEN) : w_left;
    assign w_len      = (w_4k < w_min) ? w_4k : w_min;
    assign w_next_off = r_off + (32'(r_len) << LB);
    assign w_row_end  = (w_next_off >> LB) >= r_row_beats;
    assign w_empty    = (i_img_width >> LB) == 32'd0 || i_img_height == 32'd0;
    assign w_beat     = r_state == S_R && m_axi.M_AXI_RVALID;

    assign m_axi.M_AXI_ARID    = 1'b0;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARSIZE  = 3'(LB);
    assign m_axi.M_AXI_ARADDR  = r_araddr;
    assign m_axi.M_AXI_ARLEN   = r_arlen;
    assign o_r_data            = m_axi.M_AXI_RDATA;
    assign o_read_done         = r_done;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == S_IDLE) ? (i_start ? (w_empty ? S_DONE : S_CALC) : S_IDLE) :
                       (r_state == S_CALC) ? ((32'(i_fifo_free) >= w_len) ? S_AR : S_CALC) :
                       (r_state == S_AR)   ? (m_axi.M_AXI_ARREADY ? S_R : S_AR) :
                       (r_state == S_R)    ? ((m_axi.M_AXI_RVALID && m_axi.M_AXI_RLAST) ? S_NEXT : S_R) :
                       (r_state == S_NEXT) ? ((w_abort || (w_row_end && r_rows == 32'd1)) ? S_DONE : S_CALC) :
                       S_IDLE;
    end

    always_comb begin
        m_axi.M_AXI_ARVALID = r_state == S_AR;
        m_axi.M_AXI_RREADY  = r_state == S_R;
        o_fifo_push         = w_beat;
        o_busy              = r_state != S_IDLE;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_base      <= '0;
            r_araddr    <= '0;
            r_off       <= '0;
            r_row_beats <= '0;
            r_rows      <= '0;
            r_stride    <= '0;
            r_len       <= '0;
            r_arlen     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= r_state == S_DONE;
            if (r_state == S_IDLE && i_start) begin
                r_base      <= i_src_addr & ~AW'(BYTES - 1);
                r_off       <= '0;
                r_row_beats <= i_img_width >> LB;
                r_rows      <= i_img_height;
                r_stride    <= i_img_stride & ~32'(BYTES - 1);
            end
            // burst parameters are frozen here so ARADDR/ARLEN hold through any AR stall
            if (r_state == S_CALC && w_state_next == S_AR) begin
                r_len    <= 9'(w_len);
                r_araddr <= w_addr;
                r_arlen  <= 8'(w_len - 32'd1);
            end
            if (r_state == S_NEXT) begin
                r_off <= w_row_end ? '0 : w_next_off;
                if (w_row_end) begin
                    r_base <= r_base + AW'(r_stride);
                    r_rows <= r_rows - 32'd1;
                end
            end
        end
    end

`ifdef DMA2D_ERR_ABORT_EN
    logic r_err;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN)                 r_err <= 1'b0;
        else if (r_state == S_IDLE && i_start) r_err <= 1'b0;
        else if (w_beat && m_axi.M_AXI_RRESP[1]) r_err <= 1'b1;
    end

    assign o_err    = r_err;
    assign w_abort  = r_err;
    assign w_unused = m_axi.M_AXI_RRESP[0];
`else
    assign o_err    = 1'b0;
    assign w_abort  = 1'b0;
    assign w_unused = ^m_axi.M_AXI_RRESP;
`endif
endmodule

// File: tb/tb_dma_2d_read_master_v2.sv
// tb_dma_2d_read_master_v2: directed scenarios against a queue-based transfer model and an AXI read slave.
`timescale 1ns/1ps
module tb_dma_2d_read_master_v2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic i_start = 1'b0;
    logic [31:0] i_src_addr = '0, i_img_width = '0, i_img_height = '0, i_img_stride = '0;
    logic [9:0] i_fifo_free = 10'd512;
    logic o_fifo_push, o_busy, o_read_done, o_err;
    logic [DW-1:0] o_r_data;

    int vectors = 0, fails = 0;
    int n_ar = 0, n_push = 0, n_done = 0, n_stall = 0;
    int ar_delay_cfg = 0;
    logic err_inj = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] q_ar_addr[$];
    logic [7:0]  q_ar_len[$];
    logic [31:0] q_dat[$];
    logic prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0] prev_len = '0;

    always #5 clk = ~clk;

    dma_2d_read_master_v2_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) axi ();

    dma_2d_read_master_v2 #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_BURST_LEN(256), .C_FIFO_CNT_WIDTH(10)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_img_width(i_img_width), .i_img_height(i_img_height),
        .i_img_stride(i_img_stride), .i_fifo_free(i_fifo_free), .o_fifo_push(o_fifo_push),
        .o_r_data(o_r_data), .o_busy(o_busy), .o_read_done(o_read_done), .o_err(o_err),
        .m_axi(axi)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Expected bursts and FIFO words, derived row by row from the transfer rules
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ht, input logic [31:0] st);
        logic [31:0] ab, sb, row, cur;
        int unsigned bpr, done, n, to4k;
        ab = a & ~32'h3;
        sb = st & ~32'h3;
        bpr = wd >> 2;
        if (bpr == 0 || ht == 0) return;
        for (int unsigned r = 0; r < ht; r++) begin
            row = ab + r * sb;
            done = 0;
            while (done < bpr) begin
                cur = row + done * 4;
                to4k = (4096 - (cur % 4096)) / 4;
                n = 256;
                if (bpr - done < n) n = bpr - done;
                if (to4k < n) n = to4k;
                q_ar_addr.push_back(cur);
                q_ar_len.push_back(8'(n - 1));
                for (int unsigned k = 0; k < n; k++) q_dat.push_back(dat(cur + k * 4));
                done += n;
            end
        end
    endtask

    // AXI read slave: optional ARREADY delay, R beats with a bubble every fifth cycle
    initial begin : slave
        logic [31:0] sa[$];
        logic [7:0] sl[$];
        logic af, rf, seen;
        logic [31:0] fa;
        logic [7:0] fl;
        int beat, cyc, cnt;
        beat = 0; cyc = 0; cnt = 0; seen = 1'b0; fa = '0; fl = '0;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RDATA = '0;
        axi.M_AXI_RRESP = 2'b00;
        axi.M_AXI_RLAST = 1'b0;
        forever begin
            @(negedge clk);
            af = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
            rf = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
            fa = axi.M_AXI_ARADDR;
            fl = axi.M_AXI_ARLEN;
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                sa.delete(); sl.delete();
                beat = 0; seen = 1'b0;
                axi.M_AXI_ARREADY = 1'b0;
                axi.M_AXI_RVALID = 1'b0;
                axi.M_AXI_RLAST = 1'b0;
                axi.M_AXI_RRESP = 2'b00;
            end else begin
                if (af) begin sa.push_back(fa); sl.push_back(fl); end
                if (rf && sl.size() != 0) begin
                    if (beat == int'(sl[0])) begin
                        void'(sa.pop_front()); void'(sl.pop_front()); beat = 0;
                    end else beat++;
                end
                if (axi.M_AXI_ARVALID) begin
                    if (!seen) begin seen = 1'b1; cnt = ar_delay_cfg; end
                    else if (cnt > 0) cnt--;
                end else seen = 1'b0;
                axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && cnt == 0;
                if (sa.size() != 0 && cyc % 5 != 4) begin
                    axi.M_AXI_RVALID = 1'b1;
                    axi.M_AXI_RDATA = dat(sa[0] + 32'(beat) * 4);
                    axi.M_AXI_RLAST = beat == int'(sl[0]);
                    axi.M_AXI_RRESP = (err_inj && sa[0] == err_addr && beat == 2) ? 2'b10 : 2'b00;
                end else begin
                    axi.M_AXI_RVALID = 1'b0;
                    axi.M_AXI_RLAST = 1'b0;
                    axi.M_AXI_RRESP = 2'b00;
                end
            end
        end
    end

    // Compare process: every AR handshake and every FIFO push against the model queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi.M_AXI_ARVALID) begin
                if (prev_stall) begin
                    chk("araddr_hold", axi.M_AXI_ARADDR, prev_addr);
                    chk("arlen_hold", axi.M_AXI_ARLEN, prev_len);
                end
                if (!axi.M_AXI_ARREADY) n_stall++;
                else begin
                    n_ar++;
                    chk("ar_expected", q_ar_addr.size() != 0, 1);
                    if (q_ar_addr.size() != 0) begin
                        chk("araddr", axi.M_AXI_ARADDR, q_ar_addr.pop_front());
                        chk("arlen", axi.M_AXI_ARLEN, q_ar_len.pop_front());
                    end
                    chk("credit", 32'(i_fifo_free) >= 32'(axi.M_AXI_ARLEN) + 1, 1);
                    chk("ar_const", {axi.M_AXI_ARID, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST}, {1'b0, 3'd2, 2'b01});
                end
                prev_stall = !axi.M_AXI_ARREADY;
                prev_addr = axi.M_AXI_ARADDR;
                prev_len = axi.M_AXI_ARLEN;
            end else prev_stall = 1'b0;
            if (o_fifo_push) begin
                n_push++;
                chk("push_expected", q_dat.size() != 0, 1);
                if (q_dat.size() != 0) chk("rdata", o_r_data, q_dat.pop_front());
            end
            if (o_read_done) n_done++;
            if (!o_busy) chk("idle_quiet", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, o_fifo_push}, 0);
        end else prev_stall = 1'b0;
    end

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ht, input logic [31:0] st);
        @(posedge clk);
        #1;
        i_start = 1'b1; i_src_addr = a; i_img_width = wd; i_img_height = ht; i_img_stride = st;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // mode 1: re-pulse start mid-transfer; mode 2: hold back FIFO credit before releasing it
    task automatic xfer(input string nm, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ht,
                        input logic [31:0] st, input int nar, input int npush, input logic eerr,
                        input int mode, input int budget);
        int b_ar, b_push, b_done, k, cnt;
        b_ar = n_ar; b_push = n_push; b_done = n_done;
        pulse_start(a, wd, ht, st);
        if (mode == 1) begin
            repeat (4) @(posedge clk);
            #1;
            i_start = 1'b1; i_src_addr = 32'h8000;
            @(posedge clk);
            #1;
            i_start = 1'b0; i_src_addr = a;
        end
        if (mode == 2) begin
            cnt = 0;
            repeat (30) begin
                @(negedge clk);
                if (axi.M_AXI_ARVALID) cnt++;
            end
            chk({nm, "_starved_arvalid"}, cnt, 0);
            chk({nm, "_starved_busy"}, o_busy, 1);
            @(posedge clk);
            #1;
            i_fifo_free = 10'd256;
        end
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (o_read_done) break;
        end
        chk({nm, "_done_seen"}, k < budget, 1);
        chk({nm, "_err_at_done"}, o_err, eerr);
        chk({nm, "_idle_at_done"}, o_busy, 0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, o_read_done, 0);
        chk({nm, "_ar_count"}, n_ar - b_ar, nar);
        chk({nm, "_push_count"}, n_push - b_push, npush);
        chk({nm, "_done_count"}, n_done - b_done, 1);
        chk({nm, "_ar_left"}, q_ar_addr.size(), 0);
        chk({nm, "_data_left"}, q_dat.size(), 0);
    endtask

    initial begin : main
        int b_stall, b_ar, k;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_arvalid", axi.M_AXI_ARVALID, 0);
        chk("rst_rready", axi.M_AXI_RREADY, 0);
        chk("rst_push", o_fifo_push, 0);
        chk("rst_done", o_read_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_araddr", axi.M_AXI_ARADDR, 0);
        chk("rst_arlen", axi.M_AXI_ARLEN, 0);
        chk("rst_ar_const", {axi.M_AXI_ARID, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST}, {1'b0, 3'd2, 2'b01});
        rst_n = 1'b1;

        model(32'h1000, 64, 2, 256);
        chk("m1_bursts", q_ar_addr.size(), 2);
        chk("m1_addr0", q_ar_addr[0], 32'h1000);
        chk("m1_len0", q_ar_len[0], 15);
        chk("m1_addr1", q_ar_addr[1], 32'h1100);
        chk("m1_len1", q_ar_len[1], 15);
        chk("m1_words", q_dat.size(), 32);
        xfer("s1", 32'h1000, 64, 2, 256, 2, 32, 1'b0, 0, 500);

        model(32'h0FF0, 64, 1, 0);
        chk("m2_addr0", q_ar_addr[0], 32'h0FF0);
        chk("m2_len0", q_ar_len[0], 3);
        chk("m2_addr1", q_ar_addr[1], 32'h1000);
        chk("m2_len1", q_ar_len[1], 11);
        xfer("s2", 32'h0FF0, 64, 1, 0, 2, 16, 1'b0, 0, 500);

        i_fifo_free = 10'd100;
        model(32'h2000, 2048, 1, 0);
        chk("m3_bursts", q_ar_addr.size(), 2);
        chk("m3_len0", q_ar_len[0], 255);
        chk("m3_addr1", q_ar_addr[1], 32'h2400);
        chk("m3_len1", q_ar_len[1], 255);
        xfer("s3", 32'h2000, 2048, 1, 0, 2, 512, 1'b0, 2, 2000);
        i_fifo_free = 10'd512;

        ar_delay_cfg = 10;
        b_stall = n_stall;
        model(32'h1000, 64, 2, 256);
        xfer("s4", 32'h1000, 64, 2, 256, 2, 32, 1'b0, 1, 800);
        chk("s4_stall_cycles", n_stall - b_stall, 20);
        ar_delay_cfg = 0;

        b_ar = n_ar;
        pulse_start(32'h1000, 64, 0, 256);
        @(negedge clk);
        chk("s5_done_early", o_read_done, 0);
        chk("s5_busy_done_state", o_busy, 1);
        @(negedge clk);
        chk("s5_done_at_2", o_read_done, 1);
        chk("s5_idle_at_2", o_busy, 0);
        @(negedge clk);
        chk("s5_done_once", o_read_done, 0);
        pulse_start(32'h1000, 3, 4, 256);
        @(negedge clk);
        chk("s5w_done_early", o_read_done, 0);
        @(negedge clk);
        chk("s5w_done_at_2", o_read_done, 1);
        chk("s5_no_ar", n_ar - b_ar, 0);

        model(32'h3000, 64, 1, 0);
        pulse_start(32'h3000, 64, 1, 0);
        k = 0;
        for (int c = 0; c < 300 && k < 3; c++) begin
            @(negedge clk);
            if (o_fifo_push) k++;
        end
        chk("s5r_reached_r", k, 3);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("s5r_arvalid", axi.M_AXI_ARVALID, 0);
        chk("s5r_rready", axi.M_AXI_RREADY, 0);
        chk("s5r_push", o_fifo_push, 0);
        chk("s5r_busy", o_busy, 0);
        chk("s5r_done", o_read_done, 0);
        chk("s5r_err", o_err, 0);
        chk("s5r_araddr", axi.M_AXI_ARADDR, 0);
        chk("s5r_arlen", axi.M_AXI_ARLEN, 0);
        q_ar_addr.delete(); q_ar_len.delete(); q_dat.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        model(32'h0FF0, 64, 1, 0);
        xfer("s2r", 32'h0FF0, 64, 1, 0, 2, 16, 1'b0, 0, 500);

        err_inj = 1'b1;
        err_addr = 32'h10000;
        model(32'h10000, 4096, 1, 0);
        chk("m6_bursts", q_ar_addr.size(), 4);
`ifdef DMA2D_ERR_ABORT_EN
        while (q_ar_addr.size() > 1) begin void'(q_ar_addr.pop_back()); void'(q_ar_len.pop_back()); end
        while (q_dat.size() > 256) void'(q_dat.pop_back());
        xfer("s6", 32'h10000, 4096, 1, 0, 1, 256, 1'b1, 0, 1000);
        chk("s6_err_sticky", o_err, 1);
        err_inj = 1'b0;
        model(32'h1000, 64, 1, 0);
        xfer("s6c", 32'h1000, 64, 1, 0, 1, 16, 1'b0, 0, 500);
`else
        xfer("s6", 32'h10000, 4096, 1, 0, 4, 1024, 1'b0, 0, 3000);
        err_inj = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
